// File: rtl/csr_pkg.sv
// Shared definitions for the machine-mode trap CSR file: CSR addresses,
// mstatus bit positions, interrupt cause codes and the trap sequencer states.
package csr_pkg;

    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MIP      = 12'h344;

    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    // Interrupt codes double as the bit positions in mip/mie.
    localparam logic [3:0] INT_CODE_SOFT  = 4'd3;
    localparam logic [3:0] INT_CODE_TIMER = 4'd7;
    localparam logic [3:0] INT_CODE_EXT   = 4'd11;

    localparam logic [31:0] MIE_MASK = 32'h0000_0888;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REDIRECT,
        ST_SETTLE
    } trap_state_e;

endpackage

// File: rtl/trap_int_sel.sv
// Fixed-priority interrupt select: external > software > timer.
module trap_int_sel
    import csr_pkg::*;
(
    input  logic [31:0] mip_i,
    input  logic [31:0] mie_i,
    output logic        int_en_o,
    output logic [3:0]  int_code_o
);

    logic [31:0] pend;
    logic        unused_pend;

    assign pend        = mip_i & mie_i;
    assign unused_pend = ^{pend[31:12], pend[10:8], pend[6:4], pend[2:0]};

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        int_en_o   = 1'b0;
        int_code_o = 4'd0;
        if (pend[INT_CODE_EXT]) begin
            int_en_o   = 1'b1;
            int_code_o = INT_CODE_EXT;
        end else if (pend[INT_CODE_SOFT]) begin
            int_en_o   = 1'b1;
            int_code_o = INT_CODE_SOFT;
        end else if (pend[INT_CODE_TIMER]) begin
            int_en_o   = 1'b1;
            int_code_o = INT_CODE_TIMER;
        end
    end

endmodule

// File: rtl/trap_csr.sv
// Machine-mode trap CSR file and trap/mret sequencer driving pipeline flush
// and redirect for the upstream trap unit.
module trap_csr
    import csr_pkg::*;
#(
    parameter logic [31:0] RESET_VEC     = 32'h0000_0000,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        MMU_WAIT,
    input  logic        TRAP_EN,
    input  logic [31:0] TRAP_CODE,
    input  logic [31:0] TRAP_PC,
    input  logic [31:0] TRAP_JMP_TO,
    input  logic        EXC_EN,
    input  logic        MRET_EN,
    input  logic        INT_EXT,
    input  logic        INT_TIMER,
    input  logic        INT_SOFT,
    input  logic        CSR_WR_EN,
    input  logic [11:0] CSR_WR_ADDR,
    input  logic [31:0] CSR_WR_DATA,
    input  logic        CSR_RD_EN,
    input  logic [11:0] CSR_RD_ADDR,
    output logic [31:0] CSR_RD_DATA,
    output logic        CSR_RD_VALID,
    output logic        INT_ALLOW,
    output logic        INT_EN,
    output logic [3:0]  INT_CODE,
    output logic [1:0]  TRAP_VEC_MODE,
    output logic [31:0] TRAP_VEC_BASE,
    output logic        FLUSH,
    output logic        NEW_PC_EN,
    output logic [31:0] NEW_PC
);

    localparam int unsigned CNT_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

    trap_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [31:0] new_pc_q, new_pc_d;
    logic [31:0] mepc_q, mepc_d;
    logic [31:0] mcause_q, mcause_d;
    logic [31:0] mie_q, mie_d;
    logic [31:0] mtvec_q, mtvec_d;
    logic [31:0] mscratch_q, mscratch_d;
    logic        st_mie_q, st_mie_d;
    logic        st_mpie_q, st_mpie_d;
    logic        exc_q, exc_d;
    logic [31:0] rd_data_q, rd_data_d;
    logic        rd_valid_q, rd_valid_d;

    logic [31:0] mstatus;
    logic [31:0] mip;
    logic [31:0] rd_mux;
    logic        unused_code;

    assign unused_code = ^TRAP_CODE[31:4];

    always_comb begin
        mstatus               = '0;
        mstatus[MSTATUS_MIE]  = st_mie_q;
        mstatus[MSTATUS_MPIE] = st_mpie_q;
        mip                   = '0;
        mip[INT_CODE_EXT]     = INT_EXT;
        mip[INT_CODE_TIMER]   = INT_TIMER;
        mip[INT_CODE_SOFT]    = INT_SOFT;
    end

    always_comb begin
        rd_mux = '0;
        case (CSR_RD_ADDR)
            CSR_MSTATUS:  rd_mux = mstatus;
            CSR_MIE:      rd_mux = mie_q;
            CSR_MTVEC:    rd_mux = mtvec_q;
            CSR_MSCRATCH: rd_mux = mscratch_q;
            CSR_MEPC:     rd_mux = mepc_q;
            CSR_MCAUSE:   rd_mux = mcause_q;
            CSR_MIP:      rd_mux = mip;
            default:      rd_mux = '0;
        endcase
    end

    trap_int_sel u_int_sel (
        .mip_i      (mip),
        .mie_i      (mie_q),
        .int_en_o   (INT_EN),
        .int_code_o (INT_CODE)
    );

    assign TRAP_VEC_BASE = {mtvec_q[31:2], 2'b00};
    assign TRAP_VEC_MODE = mtvec_q[1:0];
    assign INT_ALLOW     = st_mie_q && (state_q == ST_IDLE);
    assign FLUSH         = (state_q == ST_REDIRECT) && !MMU_WAIT;
    assign NEW_PC_EN     = FLUSH;
    assign NEW_PC        = new_pc_q;
    assign CSR_RD_DATA   = rd_data_q;
    assign CSR_RD_VALID  = rd_valid_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        new_pc_d   = new_pc_q;
        mepc_d     = mepc_q;
        mcause_d   = mcause_q;
        mie_d      = mie_q;
        mtvec_d    = mtvec_q;
        mscratch_d = mscratch_q;
        st_mie_d   = st_mie_q;
        st_mpie_d  = st_mpie_q;
        exc_d      = exc_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_valid_q;

        if (!MMU_WAIT) begin
            exc_d      = FLUSH ? 1'b0 : EXC_EN;
            rd_valid_d = CSR_RD_EN;
            if (CSR_RD_EN) rd_data_d = rd_mux;

            if (CSR_WR_EN) begin
                case (CSR_WR_ADDR)
                    CSR_MSTATUS: begin
                        st_mie_d  = CSR_WR_DATA[MSTATUS_MIE];
                        st_mpie_d = CSR_WR_DATA[MSTATUS_MPIE];
                    end
                    CSR_MIE:      mie_d      = CSR_WR_DATA & MIE_MASK;
                    CSR_MTVEC:    mtvec_d    = CSR_WR_DATA & ~32'h2;
                    CSR_MSCRATCH: mscratch_d = CSR_WR_DATA;
                    CSR_MEPC:     mepc_d     = CSR_WR_DATA & ~32'h3;
                    CSR_MCAUSE:   mcause_d   = CSR_WR_DATA;
                    default: ;
                endcase
            end

            // Trap/mret commits come after the CSR write so they override it.
            case (state_q)
                ST_IDLE: begin
                    if (TRAP_EN) begin
                        mepc_d    = TRAP_PC & ~32'h3;
                        mcause_d  = {~exc_q, 27'b0, TRAP_CODE[3:0]};
                        st_mpie_d = st_mie_q;
                        st_mie_d  = 1'b0;
                        new_pc_d  = TRAP_JMP_TO;
                        state_d   = ST_REDIRECT;
                    end else if (MRET_EN) begin
                        st_mie_d  = st_mpie_q;
                        st_mpie_d = 1'b1;
                        new_pc_d  = mepc_q;
                        state_d   = ST_REDIRECT;
                    end
                end
                ST_REDIRECT: begin
                    cnt_d   = CNT_W'(SETTLE_CYCLES);
                    state_d = ST_SETTLE;
                end
                ST_SETTLE: begin
                    if (cnt_q <= CNT_W'(1)) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            new_pc_q   <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mie_q      <= '0;
            mtvec_q    <= RESET_VEC;
            mscratch_q <= '0;
            st_mie_q   <= 1'b0;
            st_mpie_q  <= 1'b0;
            exc_q      <= 1'b0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            new_pc_q   <= new_pc_d;
            mepc_q     <= mepc_d;
            mcause_q   <= mcause_d;
            mie_q      <= mie_d;
            mtvec_q    <= mtvec_d;
            mscratch_q <= mscratch_d;
            st_mie_q   <= st_mie_d;
            st_mpie_q  <= st_mpie_d;
            exc_q      <= exc_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

endmodule

// File: tb/tb_trap_csr.sv
// Directed self-checking bench for trap_csr: CSR access, interrupt select,
// trap/mret sequencing, stall handling and reset abort.
module tb_trap_csr;
    import csr_pkg::*;

    localparam logic [31:0] RVEC = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        rst, mmu_wait, trap_en, exc_en, mret_en;
    logic [31:0] trap_code, trap_pc, trap_jmp_to;
    logic        int_ext, int_timer, int_soft;
    logic        csr_wr_en, csr_rd_en;
    logic [11:0] csr_wr_addr, csr_rd_addr;
    logic [31:0] csr_wr_data, csr_rd_data;
    logic        csr_rd_valid, int_allow, int_en, flush, new_pc_en;
    logic [3:0]  int_code;
    logic [1:0]  vec_mode;
    logic [31:0] vec_base, new_pc;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    trap_csr #(.RESET_VEC(RVEC), .SETTLE_CYCLES(2)) dut (
        .CLK(clk), .RST(rst), .MMU_WAIT(mmu_wait),
        .TRAP_EN(trap_en), .TRAP_CODE(trap_code), .TRAP_PC(trap_pc), .TRAP_JMP_TO(trap_jmp_to),
        .EXC_EN(exc_en), .MRET_EN(mret_en),
        .INT_EXT(int_ext), .INT_TIMER(int_timer), .INT_SOFT(int_soft),
        .CSR_WR_EN(csr_wr_en), .CSR_WR_ADDR(csr_wr_addr), .CSR_WR_DATA(csr_wr_data),
        .CSR_RD_EN(csr_rd_en), .CSR_RD_ADDR(csr_rd_addr),
        .CSR_RD_DATA(csr_rd_data), .CSR_RD_VALID(csr_rd_valid),
        .INT_ALLOW(int_allow), .INT_EN(int_en), .INT_CODE(int_code),
        .TRAP_VEC_MODE(vec_mode), .TRAP_VEC_BASE(vec_base),
        .FLUSH(flush), .NEW_PC_EN(new_pc_en), .NEW_PC(new_pc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        csr_wr_en = 1'b1; csr_wr_addr = a; csr_wr_data = d;
        step();
        csr_wr_en = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
        csr_rd_en = 1'b1; csr_rd_addr = a;
        step();
        csr_rd_en = 1'b0;
        check(tag, csr_rd_data, exp);
        check({tag, "_vld"}, csr_rd_valid, 1);
    endtask

    initial begin
        rst = 1'b1; mmu_wait = 0; trap_en = 0; exc_en = 0; mret_en = 0;
        trap_code = 0; trap_pc = 0; trap_jmp_to = 0;
        int_ext = 0; int_timer = 0; int_soft = 0;
        csr_wr_en = 0; csr_rd_en = 0; csr_wr_addr = 0; csr_rd_addr = 0; csr_wr_data = 0;

        // Reset state
        step(); step();
        check("rst_flush", flush, 0);
        check("rst_newpc_en", new_pc_en, 0);
        check("rst_newpc", new_pc, 0);
        check("rst_rd_valid", csr_rd_valid, 0);
        check("rst_rd_data", csr_rd_data, 0);
        check("rst_int_allow", int_allow, 0);
        check("rst_int_en", int_en, 0);
        check("rst_int_code", int_code, 0);
        rst = 1'b0;
        rd("rst_mstatus", CSR_MSTATUS, 32'h0);
        rd("rst_mie", CSR_MIE, 32'h0);
        rd("rst_mtvec", CSR_MTVEC, RVEC);
        rd("rst_mscratch", CSR_MSCRATCH, 32'h0);
        rd("rst_mepc", CSR_MEPC, 32'h0);
        rd("rst_mcause", CSR_MCAUSE, 32'h0);
        wr(12'h123, 32'hFFFF_FFFF);
        rd("unimpl", 12'h123, 32'h0);

        // Configure and check interrupt select
        wr(CSR_MTVEC, 32'h8000_0001);
        wr(CSR_MIE, 32'h0000_0880);
        check("allow_pre_mstatus", int_allow, 0);
        wr(CSR_MSTATUS, 32'h0000_0008);
        check("allow_post_mstatus", int_allow, 1);
        int_ext = 1; int_timer = 1; #1;
        check("int_en_ext", int_en, 1);
        check("int_code_ext", int_code, 11);
        check("vec_mode", vec_mode, 1);
        check("vec_base", vec_base, 32'h8000_0000);
        rd("mip", CSR_MIP, 32'h0000_0880);
        int_soft = 1; #1;
        check("soft_masked", int_code, 11);
        wr(CSR_MIE, 32'hFFFF_FFFF);
        rd("mie_mask", CSR_MIE, 32'h0000_0888);
        int_ext = 0; #1;
        check("int_code_soft", int_code, 3);
        int_soft = 0; #1;
        check("int_code_timer", int_code, 7);
        int_timer = 0; #1;
        check("int_en_none", int_en, 0);
        check("int_code_none", int_code, 0);

        // Interrupt trap, mepc low bits masked
        trap_en = 1; trap_pc = 32'h0000_0107; trap_code = 32'd11; trap_jmp_to = 32'h8000_002C;
        step();
        trap_en = 0;
        check("trap_flush", flush, 1);
        check("trap_newpc_en", new_pc_en, 1);
        check("trap_newpc", new_pc, 32'h8000_002C);
        check("trap_allow_redir", int_allow, 0);
        step();
        check("trap_flush_once", flush, 0);
        rd("trap_mepc", CSR_MEPC, 32'h0000_0104);
        rd("trap_mcause", CSR_MCAUSE, 32'h8000_000B);
        rd("trap_mstatus", CSR_MSTATUS, 32'h0000_0080);

        // mret, trap ignored in SETTLE, settle length via INT_ALLOW
        mret_en = 1;
        step();
        mret_en = 0;
        check("mret_flush", flush, 1);
        check("mret_newpc", new_pc, 32'h0000_0104);
        check("mret_allow_redir", int_allow, 0);
        step();
        check("settle1_allow", int_allow, 0);
        trap_en = 1; trap_pc = 32'h200; trap_code = 32'd5; trap_jmp_to = 32'h9000_0000;
        step();
        trap_en = 0;
        check("settle2_allow", int_allow, 0);
        check("settle2_flush", flush, 0);
        step();
        check("idle_allow", int_allow, 1);
        check("ignored_trap_flush", flush, 0);
        rd("mret_mstatus", CSR_MSTATUS, 32'h0000_0088);
        rd("mret_mcause_keep", CSR_MCAUSE, 32'h8000_000B);
        rd("mret_mepc_keep", CSR_MEPC, 32'h0000_0104);

        // Trap + mret together with exception; concurrent mscratch write
        exc_en = 1;
        step();
        trap_en = 1; mret_en = 1; trap_code = 32'd2; trap_pc = 32'h300; trap_jmp_to = 32'h8000_0000;
        csr_wr_en = 1; csr_wr_addr = CSR_MSCRATCH; csr_wr_data = 32'hDEAD_BEEF;
        step();
        trap_en = 0; mret_en = 0; exc_en = 0; csr_wr_en = 0;
        check("both_flush", flush, 1);
        check("both_newpc", new_pc, 32'h8000_0000);
        step(); step(); step();
        rd("exc_mcause", CSR_MCAUSE, 32'h0000_0002);
        rd("exc_mstatus", CSR_MSTATUS, 32'h0000_0080);
        rd("exc_mepc", CSR_MEPC, 32'h0000_0300);
        rd("concurrent_mscratch", CSR_MSCRATCH, 32'hDEAD_BEEF);

        // Read and write same address in one cycle returns old value
        csr_rd_en = 1; csr_rd_addr = CSR_MSCRATCH;
        wr(CSR_MSCRATCH, 32'h0000_1234);
        csr_rd_en = 0;
        check("rdw_old", csr_rd_data, 32'hDEAD_BEEF);
        rd("rdw_new", CSR_MSCRATCH, 32'h0000_1234);

        // Stall at a trap: nothing accepted, writes frozen
        mmu_wait = 1; trap_en = 1; trap_code = 32'd7; trap_pc = 32'h400; trap_jmp_to = 32'h8000_0040;
        csr_wr_en = 1; csr_wr_addr = CSR_MSCRATCH; csr_wr_data = 32'hFFFF_FFFF;
        step();
        csr_wr_en = 0;
        check("stall1_flush", flush, 0);
        step();
        check("stall2_flush", flush, 0);
        step();
        check("stall3_flush", flush, 0);
        mmu_wait = 0;
        csr_wr_en = 1; csr_wr_addr = CSR_MEPC; csr_wr_data = 32'h0000_5550;
        step();
        trap_en = 0; csr_wr_en = 0;
        check("release_flush", flush, 1);
        check("release_newpc", new_pc, 32'h8000_0040);
        mmu_wait = 1; #1;
        check("redir_stall_flush", flush, 0);
        step();
        check("redir_held_flush", flush, 0);
        mmu_wait = 0; #1;
        check("redir_resume_flush", flush, 1);
        step();
        check("redir_done_flush", flush, 0);
        step(); step();
        rd("stall_mscratch", CSR_MSCRATCH, 32'h0000_1234);
        rd("stall_mepc", CSR_MEPC, 32'h0000_0400);
        rd("stall_mcause", CSR_MCAUSE, 32'h8000_0007);
        rd("stall_mstatus", CSR_MSTATUS, 32'h0);

        // Reset in REDIRECT aborts the trap
        trap_en = 1; trap_pc = 32'h600; trap_jmp_to = 32'hA000_0000;
        step();
        trap_en = 0;
        check("abort_pre_flush", flush, 1);
        rst = 1;
        step();
        rst = 0;
        check("abort_flush", flush, 0);
        check("abort_newpc", new_pc, 32'h0);
        step();
        check("abort_flush_late", flush, 0);
        rd("abort_mepc", CSR_MEPC, 32'h0);
        rd("abort_mtvec", CSR_MTVEC, RVEC);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/trap_csr.md
# trap_csr

Machine-mode trap CSR file and trap sequencer that sits on the receiving side of the pipeline `trap` unit. It supplies the vector mode/base and the interrupt request/permission inputs that `trap` consumes. It accepts `trap`'s `TRAP_EN`/`TRAP_CODE`/`TRAP_PC`/`TRAP_JMP_TO` outputs, commits `mepc`/`mcause`/`mstatus`, and drives the pipeline flush and redirect. It also executes `mret`.

## Interface
- `RESET_VEC`, default 32'h0000_0000: reset value of `mtvec`.
- `SETTLE_CYCLES`, default 2: cycles after a redirect during which new traps and `mret` are ignored.
---
- `CLK`  in  1  clock.
- `RST`  in  1  reset, synchronous, active-high.
- `MMU_WAIT`  in  1  pipeline stall. All state is frozen and no event is accepted.
- `TRAP_EN`, `TRAP_CODE[31:0]`, `TRAP_PC[31:0]`, `TRAP_JMP_TO[31:0]`  in  trap request from `trap`.
- `EXC_EN`  in  1  the same exception-valid flag that feeds `trap`, used to classify the cause.
- `MRET_EN`  in  1  `mret` retired in the cushion stage.
- `INT_EXT`, `INT_TIMER`, `INT_SOFT`  in  1 each  level interrupt lines.
- `CSR_WR_EN`  in  1  CSR write strobe.
- `CSR_WR_ADDR[11:0]`, `CSR_WR_DATA[31:0]`  in  CSR write address and data.
- `CSR_RD_EN`  in  1  CSR read strobe.
- `CSR_RD_ADDR[11:0]`  in  12  CSR read address.
- `CSR_RD_DATA[31:0]`  out  read data, registered.
- `CSR_RD_VALID`  out  1  read data valid, registered.
- `INT_ALLOW`, `INT_EN`  out  1 each  to `trap`.
- `INT_CODE[3:0]`  out  4  to `trap`.
- `TRAP_VEC_MODE[1:0]`, `TRAP_VEC_BASE[31:0]`  out  vector mode and base, to `trap`.
- `FLUSH`  out  1  pipeline flush, one-cycle pulse.
- `NEW_PC_EN`  out  1  redirect strobe, one-cycle pulse.
- `NEW_PC[31:0]`  out  32  redirect target.

## Operation
- CSRs implemented:
  - `mstatus` 0x300: `MIE` bit 3, `MPIE` bit 7. All other bits read as 0.
  - `mie` 0x304: `MSIE` bit 3, `MTIE` bit 7, `MEIE` bit 11.
  - `mtvec` 0x305: base in [31:2]. Mode in [1:0], where bit 1 is hardwired 0.
  - `mscratch` 0x340.
  - `mepc` 0x341: bits [1:0] are forced to 0 on every write.
  - `mcause` 0x342.
  - `mip` 0x344: read-only. Bits 3/7/11 reflect `INT_SOFT`/`INT_TIMER`/`INT_EXT`.
- Unimplemented addresses read as 0. Writes to them are ignored.
- `TRAP_VEC_BASE = {mtvec[31:2], 2'b00}`. `TRAP_VEC_MODE = mtvec[1:0]`.
- Interrupt select: `pend = mip & mie`. Priority is external (code 11) > software (3) > timer (7). `INT_EN = |pend`. `INT_CODE` is the winning code, or 0 when nothing is pending.
- `INT_ALLOW = mstatus.MIE && state==IDLE`.
- The FSM has three states: IDLE, REDIRECT, SETTLE.
- IDLE with `TRAP_EN` (and `MMU_WAIT` low):
  - `mepc <= TRAP_PC & ~3`.
  - `mcause <= {exc_q ? 1'b0 : 1'b1, 27'b0, TRAP_CODE[3:0]}`. `exc_q` is `EXC_EN` registered under the same `RST`/`FLUSH`/`MMU_WAIT` rules that `trap` uses.
  - `MPIE <= MIE`, `MIE <= 0`.
  - `NEW_PC <= TRAP_JMP_TO`, then go to REDIRECT.
- IDLE with `MRET_EN` and no `TRAP_EN`:
  - `MIE <= MPIE`, `MPIE <= 1`.
  - `NEW_PC <= mepc`, then go to REDIRECT.
- REDIRECT: `FLUSH = NEW_PC_EN = 1` for exactly one cycle. Load the settle counter with `SETTLE_CYCLES`, then go to SETTLE.
- SETTLE: decrement the counter and return to IDLE at 0. `TRAP_EN` and `MRET_EN` are ignored in this state, and `INT_ALLOW` is 0.
- Simultaneous `TRAP_EN` and `MRET_EN` in IDLE: the trap wins and `mret` is dropped.
- A CSR write in the same cycle as a trap or `mret` commit:
  - Trap/`mret` updates to `mepc`, `mcause` and `mstatus` win.
  - Writes to other CSRs complete.
- A CSR write to `mstatus` in IDLE takes effect on `INT_ALLOW` the next cycle.
- `MMU_WAIT` freezes the FSM, counter, CSRs and read port. `FLUSH`/`NEW_PC_EN` are not asserted while `MMU_WAIT` is high, and a pending REDIRECT is held.

## Timing
- Reset values:
  - `mstatus=0`, `mie=0`, `mtvec=RESET_VEC`, `mepc=0`, `mcause=0`, `mscratch=0`.
  - State = IDLE.
  - `FLUSH=0`, `NEW_PC_EN=0`, `NEW_PC=0`.
  - `CSR_RD_DATA=0`, `CSR_RD_VALID=0`.
  - `INT_ALLOW=0`, `INT_EN=0`, `INT_CODE=0`.
- `RST` asserted mid-trap aborts the trap: no `FLUSH` is issued after reset.
- Trap to redirect: `TRAP_EN` is sampled in cycle N. `FLUSH`/`NEW_PC_EN` are high in cycle N+1. IDLE is re-entered at N+2+`SETTLE_CYCLES`.
- CSR read: `CSR_RD_EN` is sampled in cycle N. `CSR_RD_DATA`/`CSR_RD_VALID` are valid in cycle N+1. A read in the same cycle as a write to the same address returns the old value.
- `INT_EN`/`INT_CODE` are combinational from the interrupt lines and `mie`. `INT_ALLOW` is combinational from state and `mstatus`.

## Structure
- Shared package `csr_pkg`:
  - CSR address constants.
  - `mstatus` bit indices (`MIE`, `MPIE`).
  - Interrupt codes 3/7/11.
  - FSM state encoding.
- Sub-module `trap_int_sel`: priority select producing `INT_EN`/`INT_CODE` from `mip & mie`.

## Test plan
- Reset, then read all six CSRs → `mtvec=RESET_VEC`, all others 0. `INT_ALLOW=0`.
- Write `mtvec=0x8000_0001`, `mie=0x880`, `mstatus=0x8`. Raise `INT_EXT` and `INT_TIMER` → `INT_EN=1`, `INT_CODE=11`, `INT_ALLOW=1`, `TRAP_VEC_MODE=1`, `TRAP_VEC_BASE=0x8000_0000`.
- Pulse `TRAP_EN` with `TRAP_PC=0x104`, `TRAP_CODE=11`, `TRAP_JMP_TO=0x8000_002C`, `EXC_EN` low → next cycle `FLUSH=1` and `NEW_PC=0x8000_002C`. Then `mepc=0x104`, `mcause=0x8000_000B`, `mstatus=0x80`. `INT_ALLOW=0` through SETTLE.
- Pulse `MRET_EN` → `NEW_PC=0x104`, `mstatus=0x88`. A `TRAP_EN` issued during SETTLE is ignored.
- Assert `TRAP_EN` and `MRET_EN` together with an exception code of 2 (`EXC_EN`=1) → trap taken, `mcause=0x2`, `MIE` cleared.
- Hold `MMU_WAIT` for 3 cycles at a `TRAP_EN` → no `FLUSH` during the stall. `FLUSH` is asserted on the first cycle after the stall releases, and CSRs are unchanged until the trap commit.
